// File: rtl/l1_pkg.sv
//------------------------------------------------------------------------------
// Module   : l1_pkg
// Purpose  : Shared constants and FSM state type for the layer-1 stream-out stage
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package l1_pkg;

  localparam int N_WORDS = 1024;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 13;
  localparam int FRAC_W  = 4;
  localparam int IW      = DATA_W - FRAC_W;
  localparam int IDX_W   = $clog2(N_WORDS);

  // Layer-1 results occupy the bottom of the csel=1 memory
  localparam int L1_BASE = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/l1_stream_out_if.sv
//------------------------------------------------------------------------------
// Module   : l1_stream_out_if
// Purpose  : Result-memory read port plus valid/ready output stream
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface l1_stream_out_if #(
  parameter int ADDR_W = l1_pkg::ADDR_W,
  parameter int DATA_W = l1_pkg::DATA_W,
  parameter int IW     = l1_pkg::IW,
  parameter int IDX_W  = l1_pkg::IDX_W
);

  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              csel;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output crd, caddr_rd, csel, out_valid, out_data, out_idx, out_last,
    input  cdata_rd, out_ready
  );

  modport slave (
    input  crd, caddr_rd, csel, out_valid, out_data, out_idx, out_last,
    output cdata_rd, out_ready
  );

endinterface

`default_nettype wire

// File: rtl/l1_skid_fifo.sv
//------------------------------------------------------------------------------
// Module   : l1_skid_fifo
// Purpose  : 2-entry FIFO holding returned beats between memory and stream
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module l1_skid_fifo #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] dout,
  output logic      [1:0]       count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == 2'd0);
  assign full      = (r_count == 2'd2);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The read issuer bounds outstanding reads to two, so a push into a full,
  // non-popping FIFO indicates broken issue logic upstream.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !pop));
`endif

endmodule

`default_nettype wire

// File: rtl/l1_stream_out.sv
//------------------------------------------------------------------------------
// Module   : l1_stream_out
// Purpose  : Scans layer-1 results, streams integer parts, tracks max/frac_err
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module l1_stream_out #(
  parameter  int N_WORDS = l1_pkg::N_WORDS,
  parameter  int ADDR_W  = l1_pkg::ADDR_W,
  parameter  int DATA_W  = l1_pkg::DATA_W,
  parameter  int FRAC_W  = l1_pkg::FRAC_W,
  localparam int IW      = DATA_W - FRAC_W,
  localparam int IDX_W   = $clog2(N_WORDS)
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       start,
  output logic            busy,
  output logic            done,
  output logic [IW-1:0]   max_val,
  output logic [IDX_W-1:0] max_idx,
  output logic            frac_err,
  l1_stream_out_if.master bus
);

  import l1_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(L1_BASE);
  localparam int                BEAT_W    = IW + IDX_W + 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [ADDR_W-1:0]  r_rd_idx;
  logic [ADDR_W-1:0]  r_caddr;
  logic               r_inflight;
  logic [IDX_W-1:0]   r_inflight_idx;
  logic               r_done;
  logic               r_frac_err;
  logic [IW-1:0]      r_max_val;
  logic [IDX_W-1:0]   r_max_idx;

  logic               w_start_ok;
  logic               w_issue;
  logic               w_pop;
  logic               w_push;
  logic [2:0]         w_outstanding;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [1:0]         w_count;
  logic               w_full;
  logic               w_empty;
  logic [BEAT_W-1:0]  w_push_beat;
  logic [BEAT_W-1:0]  w_head;
  logic [IW-1:0]      w_head_data;
  logic [IDX_W-1:0]   w_head_idx;
  logic               w_head_last;

  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_pop      = !w_empty && bus.out_ready;
  assign w_push     = r_inflight;
  // Buffered beats plus the read landing this cycle, less the beat leaving
  assign w_outstanding = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_addr  = BASE_ADDR + r_rd_idx;

  assign w_push_beat = {bus.cdata_rd[DATA_W-1:FRAC_W], r_inflight_idx,
                        (r_inflight_idx == LAST_IDX)};
  assign {w_head_data, w_head_idx, w_head_last} = w_head;

  l1_skid_fifo #(
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_push_beat),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_issue && (r_rd_idx == LAST_ADDR)) w_next_state = DRAIN;
      DRAIN:   if (w_pop && w_head_last) w_next_state = DONE;
      DONE:    if (start) w_next_state = RUN;
      default: w_next_state = IDLE;
    endcase
  end

  // busy stays up through the done cycle so a chained start sees no gap
  always_comb begin
    w_issue = 1'b0;
    busy    = 1'b0;
    case (r_state)
      RUN: begin
        w_issue = (w_outstanding < 3'd2);
        busy    = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    busy = r_done;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_idx       <= '0;
      r_caddr        <= '0;
      r_inflight     <= 1'b0;
      r_inflight_idx <= '0;
      r_done         <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_rd_idx <= '0;
      end else if (w_issue) begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end
      if (w_issue) begin
        r_caddr        <= w_rd_addr;
        r_inflight_idx <= r_rd_idx[IDX_W-1:0];
      end
      r_inflight <= w_issue;
      r_done     <= (r_state == DRAIN) && w_pop && w_head_last;
    end
  end

  // Strict compare keeps the earliest index on ties
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max_val  <= '0;
      r_max_idx  <= '0;
      r_frac_err <= 1'b0;
    end else if (w_start_ok) begin
      r_max_val  <= '0;
      r_max_idx  <= '0;
      r_frac_err <= 1'b0;
    end else begin
      if (w_pop && (w_head_data > r_max_val)) begin
        r_max_val <= w_head_data;
        r_max_idx <= w_head_idx;
      end
      if (w_push && (bus.cdata_rd[FRAC_W-1:0] != '0)) begin
        r_frac_err <= 1'b1;
      end
    end
  end

  assign bus.crd       = w_issue;
  assign bus.caddr_rd  = w_issue ? w_rd_addr : r_caddr;
  assign bus.csel      = 1'b1;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head_data;
  assign bus.out_idx   = w_head_idx;
  assign bus.out_last  = !w_empty && w_head_last;

  assign done     = r_done;
  assign max_val  = r_max_val;
  assign max_idx  = r_max_idx;
  assign frac_err = r_frac_err;

endmodule

`default_nettype wire

// File: doc/l1_stream_out.md
# l1_stream_out

Downstream stage of the atrous-convolution engine. After the engine finishes, this block scans the 32×32 layer-1 result memory (csel=1, words 0..1023, 13-bit 9.4 fixed-point, already rounded up and ReLU'd). It emits each word's integer part on a valid/ready stream with index and last flag. It also reports the global maximum and its first index, and flags any word whose fraction is non-zero.

## Interface
Parameters:
- N_WORDS, 1024: layer-1 words scanned, addresses 0..N_WORDS-1.
- ADDR_W, 12: memory address width.
- DATA_W, 13: memory word width.
- FRAC_W, 4: fraction bits; integer width IW = DATA_W-FRAC_W = 9.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low (reset=0 resets; one clock; reset is asynchronous and active-low).
- start  input  1  one-cycle request to begin a scan; ignored unless IDLE or DONE.
- busy  output  1  high from the cycle after start is sampled until done.
- crd  output  1  memory read enable.
- caddr_rd  output  ADDR_W  memory read address.
- cdata_rd  input  DATA_W  read data, valid the cycle after crd=1.
- csel  output  1  memory select; constant 1 (layer-1).
- out_valid  output  1  stream beat available.
- out_ready  input  1  consumer accepts beat.
- out_data  output  IW  cdata_rd[12:4], unsigned.
- out_idx  output  10  word index of beat.
- out_last  output  1  high with beat N_WORDS-1.
- done  output  1  one-cycle pulse after last beat accepted.
- max_val  output  IW  largest out_data of the completed scan.
- max_idx  output  10  index of first occurrence of max_val.
- frac_err  output  1  sticky: some word had cdata_rd[3:0]≠0.

## Operation
- FSM: IDLE → RUN on start. RUN → DRAIN when the read for index N_WORDS-1 issues. DRAIN → DONE when the last beat handshakes; done pulses on that transition. DONE → RUN on start. DONE holds results otherwise.
- Read issue in RUN: crd=1, caddr_rd=rd_idx when (FIFO occupancy + in-flight read − pop this cycle) < 2. rd_idx increments per issue. crd=0 otherwise; caddr_rd holds its last value.
- Returning data is pushed into a 2-entry FIFO tagged with its index. The FIFO never overflows; an overflow is a design error and is asserted in simulation.
- Stream: out_valid = FIFO non-empty. out_data, out_idx and out_last come from the FIFO head. Pop on out_valid & out_ready. Payload stays stable while valid and not ready.
- Max tracker updates on each handshake with strict >: ties keep the earlier index. It clears to 0 / 0 on start.
- frac_err sets on push when cdata_rd[3:0]≠0 and clears on start.
- Reset values: busy=0, crd=0, caddr_rd=0, csel=1, out_valid=0, out_last=0, out_data=0, out_idx=0, done=0, max_val=0, max_idx=0, frac_err=0, FSM=IDLE, FIFO empty.

## Timing
- start sampled at edge E0. First crd in the cycle after E0. Data is pushed at E2, so out_valid is high after E2 (2-cycle latency).
- With out_ready held at 1: one beat per cycle, beat k accepted at E(3+k), done high for the cycle after E(N_WORDS+2) = E1026.
- Backpressure: at most 2 buffered beats plus 1 in flight. Issue resumes in the same cycle as a pop.
- start while busy: ignored. start in the same cycle as done: accepted, new scan begins.
- Reset asserted mid-scan: all state clears immediately and asynchronously. A read in flight is discarded. No done pulse.

## Structure
- Shared package l1_pkg holds N_WORDS, ADDR_W, DATA_W, FRAC_W, IW, the layer-1 base address (0), and the FSM state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, l1_skid_fifo: 2-entry FIFO carrying {data, idx, last}, with push, pop, count and full/empty.
- The top holds the FSM, the read issuer, the max tracker and frac_err.

## Test plan
- Memory word k = (k mod 512)<<4, out_ready=1, pulse start: 1024 beats, out_data=k mod 512, out_last only at idx 1023, done at E1026, max_val=511, max_idx=511, frac_err=0.
- out_ready random 30% duty: beat order and values unchanged, no drop or duplicate, payload stable while stalled, crd never issued with 3 outstanding.
- Word 700 = 0x0A1: frac_err=1 after beat 700, stays 1 until next start, out_data(700)=0x00A.
- All words 0 except words 5 and 900 = 0x3F0: max_val=63, max_idx=5.
- reset driven low at beat 400 with out_ready=1: all outputs at reset values immediately. New start rescans from idx 0 with correct results.
- start pulsed while busy at beat 10: ignored. start pulsed in the done cycle: second scan starts, busy never drops.
